softmax_sum_rx_16: RTL and testbench

AXI4-Stream slave that terminates the exponent stream produced by the softmax exp stage. It accepts one packet of exp values, stores them in a local buffer and accumulates their sum. On the packet's last beat it hands the sum and the buffered values to the divider stage through a replay valid/ready stream. It is the receiving end of the exp stage's master interface.

---
 rtl/softmax_sum_rx_16_if.sv | 30 +++
 rtl/softmax_sum_rx_16.sv | 138 +++++++++++++
 tb/tb_softmax_sum_rx_16.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/softmax_sum_rx_16_if.sv
// Handshake bundle between the softmax exp stage, this receiver and the divider.
// The slave view belongs to softmax_sum_rx_16; the master view to whatever drives it.
interface softmax_sum_rx_16_if #(
    parameter int DATA_SIZE = 16
);
    logic                   s_axis_valid_i;
    logic [2*DATA_SIZE-1:0] s_axis_data_i;
    logic                   s_axis_last_i;
    logic                   s_axis_ready_o;
    logic [DATA_SIZE+3:0]   sum_o;
    logic [7:0]             number_of_data_o;
    logic                   done_o;
    logic                   overflow_o;
    logic                   rd_valid_o;
    logic [DATA_SIZE-1:0]   rd_data_o;
    logic                   rd_last_o;
    logic                   rd_ready_i;

    modport slave (
        input  s_axis_valid_i, s_axis_data_i, s_axis_last_i, rd_ready_i,
        output s_axis_ready_o, sum_o, number_of_data_o, done_o, overflow_o,
               rd_valid_o, rd_data_o, rd_last_o
    );

    modport master (
        output s_axis_valid_i, s_axis_data_i, s_axis_last_i, rd_ready_i,
        input  s_axis_ready_o, sum_o, number_of_data_o, done_o, overflow_o,
               rd_valid_o, rd_data_o, rd_last_o
    );
endinterface

// File: rtl/softmax_sum_rx_16.sv
// Receives one packet of exp values, buffers and sums them, then replays the
// buffer to the divider stage alongside the final sum and count.
//
// state  | meaning
// RECV   | accepting exp beats, storing up to DEPTH and summing them
// REPLAY | sum/count frozen, buffer streamed out on the rd_* interface
module softmax_sum_rx_16 #(
    parameter int DATA_SIZE = 16,
    parameter int DEPTH     = 10
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    softmax_sum_rx_16_if.slave    io
);
    typedef enum logic {
        RECV   = 1'b0,
        REPLAY = 1'b1
    } state_t;

    localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_buf [DEPTH];
    logic [DATA_SIZE+3:0] r_sum;
    logic [7:0]           r_count;
    logic [7:0]           r_rd_ptr;
    logic                 r_ready;
    logic                 r_done;
    logic                 r_overflow;
    logic                 r_rd_valid;
    logic [DATA_SIZE-1:0] r_rd_data;
    logic                 r_rd_last;

    logic [DATA_SIZE-1:0] w_value;
    logic                 w_unused_lo;
    logic                 w_accept;
    logic                 w_room;
    logic                 w_store;
    logic [7:0]           w_count_next;
    logic [DATA_SIZE-1:0] w_first;
    logic [7:0]           w_ptr_next;
    logic [DATA_SIZE-1:0] w_next_data;
    logic                 w_handshake;

    assign w_value      = io.s_axis_data_i[2*DATA_SIZE-1:DATA_SIZE];
    assign w_unused_lo  = ^io.s_axis_data_i[DATA_SIZE-1:0];
    assign w_accept     = (r_state == RECV) && r_ready && io.s_axis_valid_i;
    assign w_room       = (r_count < LP_DEPTH);
    assign w_store      = w_accept && w_room;
    assign w_count_next = r_count + {7'd0, w_store};
    // A one-beat packet has not reached the buffer yet when REPLAY is entered.
    assign w_first      = (r_count == 8'd0) ? w_value : r_buf[0];
    assign w_ptr_next   = r_rd_ptr + 8'd1;
    assign w_handshake  = (r_state == REPLAY) && r_rd_valid && io.rd_ready_i;

    always_comb begin
        w_next_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ptr_next == 8'(i)) begin
                w_next_data = r_buf[i];
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= RECV;
            r_sum      <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RECV: begin
                    r_ready <= 1'b1;
                    if (w_store) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (r_count == 8'(i)) begin
                                r_buf[i] <= w_value;
                            end
                        end
                        r_sum   <= r_sum + {4'd0, w_value};
                        r_count <= w_count_next;
                    end
                    if (w_accept && !w_room) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_accept && io.s_axis_last_i) begin
                        r_state    <= REPLAY;
                        r_ready    <= 1'b0;
                        r_done     <= 1'b1;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= w_first;
                        r_rd_last  <= (w_count_next == 8'd1);
                        r_rd_ptr   <= '0;
                    end
                end
                REPLAY: begin
                    if (w_handshake) begin
                        if (r_rd_last) begin
                            r_state    <= RECV;
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_sum      <= '0;
                            r_count    <= '0;
                            r_rd_ptr   <= '0;
                            r_overflow <= 1'b0;
                            r_ready    <= 1'b1;
                        end else begin
                            r_rd_ptr  <= w_ptr_next;
                            r_rd_data <= w_next_data;
                            r_rd_last <= (w_ptr_next == r_count - 8'd1);
                        end
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

    assign io.s_axis_ready_o   = r_ready;
    assign io.sum_o            = r_sum;
    assign io.number_of_data_o = r_count;
    assign io.done_o           = r_done;
    assign io.overflow_o       = r_overflow;
    assign io.rd_valid_o       = r_rd_valid;
    assign io.rd_data_o        = r_rd_data;
    assign io.rd_last_o        = r_rd_last;
endmodule

// File: tb/tb_softmax_sum_rx_16.sv
// Directed bench for softmax_sum_rx_16: packet table plus a reset-mid-packet sequence.
module tb_softmax_sum_rx_16;
    localparam int DS    = 16;
    localparam int DEPTH = 10;

    typedef struct packed {
        logic [4:0]        n;
        logic [15:0][31:0] beat;
        logic [19:0]       sum;
        logic [7:0]        cnt;
        logic              ovf;
        logic [4:0]        rdy_pat;
        logic              hold;
        logic              gap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    softmax_sum_rx_16_if #(.DATA_SIZE(DS)) bus ();

    softmax_sum_rx_16 #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .io      (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        bit acc = 0;
        int t = 0;
        @(negedge clk);
        bus.s_axis_valid_i = 1'b1;
        bus.s_axis_data_i  = d;
        bus.s_axis_last_i  = last;
        while (!acc && t < 100) begin
            if (bus.s_axis_ready_o) acc = 1;
            @(posedge clk);
            if (!acc) @(negedge clk);
            t++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int idx = 0;
        int cyc = 0;
        bit exited = 0;
        bit prev_hs = 1;
        logic [15:0] prev_d = '0;
        logic prev_l = 1'b0;
        logic rdy;
        for (int i = 0; i < int'(v.n); i++) begin
            send_beat(v.beat[i], (i == int'(v.n) - 1));
            if (v.gap && (i % 2 == 1) && (i != int'(v.n) - 1)) begin
                @(negedge clk);
                bus.s_axis_valid_i = 1'b0;
                @(posedge clk);
            end
        end
        while (!exited && cyc < 200) begin
            @(negedge clk);
            bus.s_axis_valid_i = v.hold;
            bus.s_axis_data_i  = 32'hDEAD_BEEF;
            bus.s_axis_last_i  = v.hold;
            chk({nm, " ready_low"}, 32'(bus.s_axis_ready_o), 32'd0);
            chk({nm, " sum"}, 32'(bus.sum_o), 32'(v.sum));
            chk({nm, " count"}, 32'(bus.number_of_data_o), 32'(v.cnt));
            chk({nm, " overflow"}, 32'(bus.overflow_o), 32'(v.ovf));
            chk({nm, " done"}, 32'(bus.done_o), 32'(cyc == 0));
            chk({nm, " rd_valid"}, 32'(bus.rd_valid_o), 32'd1);
            if (!prev_hs) begin
                chk({nm, " hold_data"}, 32'(bus.rd_data_o), 32'(prev_d));
                chk({nm, " hold_last"}, 32'(bus.rd_last_o), 32'(prev_l));
            end
            chk({nm, " rd_data"}, 32'(bus.rd_data_o), 32'(v.beat[idx][31:16]));
            chk({nm, " rd_last"}, 32'(bus.rd_last_o), 32'(idx == int'(v.cnt) - 1));
            prev_d = bus.rd_data_o;
            prev_l = bus.rd_last_o;
            rdy = v.rdy_pat[cyc % 5];
            bus.rd_ready_i = rdy;
            prev_hs = rdy;
            @(posedge clk);
            if (rdy) begin
                if (idx == int'(v.cnt) - 1) exited = 1;
                idx++;
            end
            cyc++;
        end
        if (!exited) chk({nm, " replay_timeout"}, 32'd0, 32'd1);
        chk({nm, " handshakes"}, 32'(idx), 32'(v.cnt));
        #1;
        bus.rd_ready_i = 1'b0;
        chk({nm, " ready_back"}, 32'(bus.s_axis_ready_o), 32'd1);
        chk({nm, " ovf_clear"}, 32'(bus.overflow_o), 32'd0);
        chk({nm, " valid_clear"}, 32'(bus.rd_valid_o), 32'd0);
        chk({nm, " sum_clear"}, 32'(bus.sum_o), 32'd0);
        chk({nm, " count_clear"}, 32'(bus.number_of_data_o), 32'd0);
        if (!v.hold) bus.s_axis_valid_i = 1'b0;
    endtask

    initial begin
        bus.s_axis_valid_i = 1'b0;
        bus.s_axis_data_i  = '0;
        bus.s_axis_last_i  = 1'b0;
        bus.rd_ready_i     = 1'b0;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].n = 5'd3; vecs[0].beat[0] = 32'h8000_0000; vecs[0].beat[1] = 32'h4000_0000;
        vecs[0].beat[2] = 32'h2000_0000; vecs[0].sum = 20'h0E000; vecs[0].cnt = 8'd3;
        vecs[0].rdy_pat = 5'b11111;
        vecs[1].n = 5'd1; vecs[1].beat[0] = 32'hFFFF_1234; vecs[1].sum = 20'h0FFFF;
        vecs[1].cnt = 8'd1; vecs[1].rdy_pat = 5'b11111;
        vecs[2].n = 5'd12;
        for (int i = 0; i < 12; i++) vecs[2].beat[i] = 32'h0001_0000;
        vecs[2].sum = 20'h0000A; vecs[2].cnt = 8'd10; vecs[2].ovf = 1'b1;
        vecs[2].rdy_pat = 5'b11111; vecs[2].gap = 1'b1;
        vecs[3].n = 5'd3; vecs[3].beat[0] = 32'h1111_0000; vecs[3].beat[1] = 32'h2222_0000;
        vecs[3].beat[2] = 32'h3333_0000; vecs[3].sum = 20'h06666; vecs[3].cnt = 8'd3;
        vecs[3].rdy_pat = 5'b11001; vecs[3].hold = 1'b1;
        vecs[4].n = 5'd2; vecs[4].beat[0] = 32'h0300_0000; vecs[4].beat[1] = 32'h0005_0000;
        vecs[4].sum = 20'h00305; vecs[4].cnt = 8'd2; vecs[4].rdy_pat = 5'b10101;
        vecs[5].n = 5'd2; vecs[5].beat[0] = 32'h0100_0000; vecs[5].beat[1] = 32'h0200_0000;
        vecs[5].sum = 20'h00300; vecs[5].cnt = 8'd2; vecs[5].rdy_pat = 5'b11111;

        repeat (3) @(negedge clk);
        chk("rst ready", 32'(bus.s_axis_ready_o), 32'd0);
        chk("rst sum", 32'(bus.sum_o), 32'd0);
        chk("rst count", 32'(bus.number_of_data_o), 32'd0);
        chk("rst done", 32'(bus.done_o), 32'd0);
        chk("rst overflow", 32'(bus.overflow_o), 32'd0);
        chk("rst rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("rst rd_data", 32'(bus.rd_data_o), 32'd0);
        chk("rst rd_last", 32'(bus.rd_last_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready after reset", 32'(bus.s_axis_ready_o), 32'd1);

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        send_beat(32'h0A00_0000, 1'b0);
        send_beat(32'h0B00_0000, 1'b0);
        @(negedge clk);
        bus.s_axis_valid_i = 1'b0;
        chk("partial sum", 32'(bus.sum_o), 32'h1500);
        chk("partial count", 32'(bus.number_of_data_o), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async rst sum", 32'(bus.sum_o), 32'd0);
        chk("async rst count", 32'(bus.number_of_data_o), 32'd0);
        chk("async rst ready", 32'(bus.s_axis_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no done after reset", 32'(bus.done_o), 32'd0);
            chk("no valid after reset", 32'(bus.rd_valid_o), 32'd0);
        end
        run_vec(vecs[5], "vec5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
